// File: rtl/mem_arbiter.sv
// Arbitrates I-fetch and D ports onto one mem_system, one request in flight; D wins ties unless
// ARB_ROUND_ROBIN_EN is defined, which alternates grants when both ports request in the same cycle.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data_out,
  output logic              i_done,
  output logic              i_stall,
  output logic              i_hit,
  output logic              i_err,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_in,
  output logic [DATA_W-1:0] d_data_out,
  output logic              d_done,
  output logic              d_stall,
  output logic              d_hit,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              mem_hit,
  input  logic              mem_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;      // 1 = D port owns the transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              err_acc_q, err_acc_d;

  logic              i_done_q, i_done_d;
  logic              i_hit_q, i_hit_d;
  logic              i_err_q, i_err_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic              d_done_q, d_done_d;
  logic              d_hit_q, d_hit_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;

  logic              i_vld, d_vld, d_wins, d_illegal;
  logic              unused_mem_stall;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_grant_q, last_grant_d;
`endif

  // Sequencing relies solely on mem_done; the subsystem's stall is informational.
  assign unused_mem_stall = mem_stall;

  always_comb begin
    i_vld     = i_rd;
    d_vld     = d_rd | d_wr;
    d_illegal = d_rd & d_wr;
`ifdef ARB_ROUND_ROBIN_EN
    d_wins    = d_vld & (~i_vld | ~last_grant_q);
`else
    d_wins    = d_vld;
`endif
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    err_acc_d = err_acc_q;
    i_done_d  = 1'b0;
    i_hit_d   = 1'b0;
    i_err_d   = 1'b0;
    i_data_d  = '0;
    d_done_d  = 1'b0;
    d_hit_d   = 1'b0;
    d_err_d   = 1'b0;
    d_data_d  = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_vld || d_vld) begin
          owner_d   = d_wins;
          err_acc_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = d_wins;
`endif
          if (d_wins) begin
            addr_d  = d_addr;
            wdata_d = d_data_in;
            if (d_illegal) begin
              // Conflicting read+write is never issued; answer with an error directly.
              state_d  = RESP;
              d_done_d = 1'b1;
              d_err_d  = 1'b1;
            end else begin
              state_d  = BUSY;
              mem_rd_d = d_rd;
              mem_wr_d = d_wr;
            end
          end else begin
            addr_d   = i_addr;
            wdata_d  = '0;
            state_d  = BUSY;
            mem_rd_d = 1'b1;
            mem_wr_d = 1'b0;
          end
        end
      end

      BUSY: begin
        err_acc_d = err_acc_q | mem_err;
        if (mem_done) begin
          state_d  = RESP;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (owner_q) begin
            d_done_d = 1'b1;
            d_hit_d  = mem_hit;
            d_err_d  = err_acc_q | mem_err;
            d_data_d = mem_data_out;
          end else begin
            i_done_d = 1'b1;
            i_hit_d  = mem_hit;
            i_err_d  = err_acc_q | mem_err;
            i_data_d = mem_data_out;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      err_acc_q <= 1'b0;
      i_done_q  <= 1'b0;
      i_hit_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_data_q  <= '0;
      d_done_q  <= 1'b0;
      d_hit_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_data_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      err_acc_q <= err_acc_d;
      i_done_q  <= i_done_d;
      i_hit_q   <= i_hit_d;
      i_err_q   <= i_err_d;
      i_data_q  <= i_data_d;
      d_done_q  <= d_done_d;
      d_hit_q   <= d_hit_d;
      d_err_q   <= d_err_d;
      d_data_q  <= d_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;

  assign i_done      = i_done_q;
  assign i_hit       = i_hit_q;
  assign i_err       = i_err_q;
  assign i_data_out  = i_data_q;
  assign d_done      = d_done_q;
  assign d_hit       = d_hit_q;
  assign d_err       = d_err_q;
  assign d_data_out  = d_data_q;

  // A port stops stalling only in the cycle its own response is presented.
  assign i_stall = i_vld & ~((state_q == RESP) & ~owner_q);
  assign d_stall = d_vld & ~((state_q == RESP) & owner_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model and a latency-programmable memory stub.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_rd = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_data_out;
  logic          i_done, i_stall, i_hit, i_err;
  logic          d_rd = 1'b0, d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_data_in = '0;
  logic [DW-1:0] d_data_out;
  logic          d_done, d_stall, d_hit, d_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_done = 1'b0, mem_stall = 1'b0, mem_hit = 1'b0, mem_err = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_addr(i_addr), .i_data_out(i_data_out), .i_done(i_done),
    .i_stall(i_stall), .i_hit(i_hit), .i_err(i_err),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall), .d_hit(d_hit), .d_err(d_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_hit(mem_hit), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which transaction is in flight and in which phase (0 idle, 1 at memory, 2 answering).
  int            m_phase = 0;
  logic          m_own_d = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_wr = 1'b0;
  logic          m_err = 1'b0;
  logic          m_last_d = 1'b0;

  logic          e_idone, e_ihit, e_ierr, e_ddone, e_dhit, e_derr;
  logic [DW-1:0] e_idata, e_ddata;

  // Memory stub knobs.
  int            lat_lo = 0, lat_hi = 0, err_pct = 0, mcnt = -1;
  bit            rnd_mode = 1'b0;
  logic [DW-1:0] fix_data = '0;
  logic          fix_hit = 1'b0;

  task automatic tick();
    logic gd, ex_is, ex_ds;
    @(negedge clk);
    ex_is = i_rd && !(m_phase == 2 && !m_own_d);
    ex_ds = (d_rd || d_wr) && !(m_phase == 2 && m_own_d);
    check("i_stall", 32'(i_stall), 32'(ex_is));
    check("d_stall", 32'(d_stall), 32'(ex_ds));

    @(posedge clk);
    #1;
    {e_idone, e_ihit, e_ierr, e_ddone, e_dhit, e_derr} = '0;
    e_idata = '0;
    e_ddata = '0;
    if (rst) begin
      m_phase = 0; m_own_d = 0; m_addr = '0; m_wdata = '0; m_wr = 0; m_err = 0; m_last_d = 0;
    end else if (m_phase == 0) begin
      if (i_rd || d_rd || d_wr) begin
`ifdef ARB_ROUND_ROBIN_EN
        gd = (d_rd || d_wr) && (!i_rd || !m_last_d);
`else
        gd = d_rd || d_wr;
`endif
        m_last_d = gd;
        m_own_d  = gd;
        m_err    = 1'b0;
        m_addr   = gd ? d_addr : i_addr;
        m_wdata  = gd ? d_data_in : '0;
        m_wr     = gd && d_wr;
        if (gd && d_rd && d_wr) begin
          m_phase = 2; e_ddone = 1; e_derr = 1;
        end else begin
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_err = m_err | mem_err;
      if (mem_done) begin
        m_phase = 2;
        if (m_own_d) begin
          e_ddone = 1; e_ddata = mem_data_out; e_dhit = mem_hit; e_derr = m_err;
        end else begin
          e_idone = 1; e_idata = mem_data_out; e_ihit = mem_hit; e_ierr = m_err;
        end
      end
    end else begin
      m_phase = 0;
    end

    check("mem_rd", 32'(mem_rd), 32'(m_phase == 1 && !m_wr));
    check("mem_wr", 32'(mem_wr), 32'(m_phase == 1 && m_wr));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_data_in", 32'(mem_data_in), 32'(m_wdata));
    check("i_done", 32'(i_done), 32'(e_idone));
    check("i_data_out", 32'(i_data_out), 32'(e_idata));
    check("i_hit", 32'(i_hit), 32'(e_ihit));
    check("i_err", 32'(i_err), 32'(e_ierr));
    check("d_done", 32'(d_done), 32'(e_ddone));
    check("d_data_out", 32'(d_data_out), 32'(e_ddata));
    check("d_hit", 32'(d_hit), 32'(e_dhit));
    check("d_err", 32'(d_err), 32'(e_derr));

    // Memory stub answers the transaction the model says is outstanding.
    if (m_phase == 1) begin
      if (mcnt < 0) mcnt = $urandom_range(lat_hi, lat_lo);
      mem_done = (mcnt == 0);
      mcnt--;
    end else begin
      mcnt = -1;
      mem_done = rnd_mode && ($urandom % 8 == 0);
    end
    mem_err      = ($urandom % 100) < err_pct;
    mem_hit      = rnd_mode ? 1'($urandom % 2) : fix_hit;
    mem_data_out = rnd_mode ? DW'($urandom) : fix_data;
    mem_stall    = (m_phase == 1) && !mem_done;
  endtask

  task automatic wait_done(input string tag, input bit want_i, input bit want_d, input int budget);
    bit gi, gdn;
    gi  = !want_i;
    gdn = !want_d;
    for (int c = 0; c < budget && !(gi && gdn); c++) begin
      tick();
      if (e_idone && want_i) begin gi = 1; i_rd = 0; end
      if (e_ddone && want_d) begin gdn = 1; d_rd = 0; d_wr = 0; end
    end
    check(tag, 32'({gi, gdn}), 32'(2'b11));
  endtask

  task automatic agents();
    int k;
    if (!i_rd || e_idone) begin
      i_rd   = 1'($urandom % 2);
      i_addr = AW'($urandom);
    end
    if (!(d_rd || d_wr) || e_ddone) begin
      k = $urandom % 32;
      d_rd      = (k < 8) || (k == 16);
      d_wr      = (k >= 8 && k < 16) || (k == 16);
      d_addr    = AW'($urandom);
      d_data_in = DW'($urandom);
    end else if ($urandom % 10 == 0) begin
      d_addr = AW'($urandom);
    end
    rst = ($urandom % 400 == 0);
  endtask

  initial begin
    // Reset, then quiet idle.
    tick(); tick();
    rst = 0;
    for (int c = 0; c < 5; c++) tick();

    // Single instruction fetch hitting after one cycle.
    lat_lo = 1; lat_hi = 1; fix_data = 16'h1234; fix_hit = 1;
    i_rd = 1; i_addr = 16'h0040;
    wait_done("i_fetch_timeout", 1, 0, 20);

    // Simultaneous I read and D write: D first, then I.
    lat_lo = 0; lat_hi = 3; fix_data = 16'h5A5A; fix_hit = 0;
    i_rd = 1; i_addr = 16'h0080;
    d_wr = 1; d_addr = 16'h0100; d_data_in = 16'hBEEF;
    wait_done("contend_timeout", 1, 1, 40);

    // D read miss, address wiggled while the memory works.
    lat_lo = 12; lat_hi = 12; fix_data = 16'hC0DE; fix_hit = 0;
    d_rd = 1; d_addr = 16'h0200;
    for (int c = 0; c < 4; c++) tick();
    d_addr = 16'h0333; d_data_in = 16'h7777;
    wait_done("miss_timeout", 0, 1, 40);

    // Illegal read+write, then a read that sees mem_err while outstanding.
    d_rd = 1; d_wr = 1; d_addr = 16'h0404;
    wait_done("illegal_timeout", 0, 1, 10);
    lat_lo = 2; lat_hi = 2; err_pct = 100; fix_hit = 1;
    d_rd = 1; d_addr = 16'h0505;
    wait_done("err_timeout", 0, 1, 20);
    err_pct = 0;

    // Reset while the memory is busy, then the same fetch completes afresh.
    lat_lo = 10; lat_hi = 10; fix_data = 16'h0F0F;
    i_rd = 1; i_addr = 16'h0606;
    for (int c = 0; c < 4; c++) tick();
    rst = 1; tick(); rst = 0;
    lat_lo = 1; lat_hi = 1;
    wait_done("post_reset_timeout", 1, 0, 20);

    // Random traffic.
    rnd_mode = 1; lat_lo = 0; lat_hi = 12; err_pct = 5;
    for (int c = 0; c < 4000; c++) begin
      tick();
      agents();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
